matmul_tile_sequencer: RTL and testbench

//  Parametrised control sequencer between the host start/done registers and the systolic matmul core.

---
 rtl/matmul_tile_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_matmul_tile_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_sequencer.sv
// K-tiled start/done sequencer for the systolic matmul core: clears the PEs, runs num_k_tiles passes
// with stepped A/B addresses and accumulate on passes 2..N. Optional WAIT watchdog: MATMUL_SEQ_TIMEOUT_EN.
module matmul_tile_sequencer #(
  parameter int AWIDTH         = 11,
  parameter int STRIDE_WIDTH   = 8,
  parameter int TILE_CNT_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start_reg,
  input  logic                      clear_done_reg,
  input  logic [TILE_CNT_WIDTH-1:0] num_k_tiles,
  input  logic [AWIDTH-1:0]         base_addr_a,
  input  logic [AWIDTH-1:0]         base_addr_b,
  input  logic [AWIDTH-1:0]         base_addr_c,
  input  logic [STRIDE_WIDTH-1:0]   tile_step_a,
  input  logic [STRIDE_WIDTH-1:0]   tile_step_b,
  input  logic                      done_mat_mul,
  output logic                      start_mat_mul,
  output logic                      pe_resetn,
  output logic [AWIDTH-1:0]         address_mat_a,
  output logic [AWIDTH-1:0]         address_mat_b,
  output logic [AWIDTH-1:0]         address_mat_c,
  output logic                      accumulate,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                      busy,
  output logic                      done_reg,
  output logic                      error_reg
);

  typedef enum logic [2:0] {S_IDLE, S_PE_CLR, S_WAIT, S_GAP, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic                      start_q, start_d;
  logic                      pe_resetn_q, pe_resetn_d;
  logic [AWIDTH-1:0]         addr_a_q, addr_a_d;
  logic [AWIDTH-1:0]         addr_b_q, addr_b_d;
  logic [AWIDTH-1:0]         addr_c_q, addr_c_d;
  logic                      acc_q, acc_d;
  logic [TILE_CNT_WIDTH-1:0] tile_q, tile_d;
  logic [TILE_CNT_WIDTH-1:0] num_q, num_d;
  logic [STRIDE_WIDTH-1:0]   step_a_q, step_a_d;
  logic [STRIDE_WIDTH-1:0]   step_b_q, step_b_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    start_d     = start_q;
    pe_resetn_d = pe_resetn_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    addr_c_d    = addr_c_q;
    acc_d       = acc_q;
    tile_d      = tile_q;
    num_d       = num_q;
    step_a_d    = step_a_q;
    step_b_d    = step_b_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    unique case (state_q)
      S_IDLE: if (start_reg) begin
        num_d    = num_k_tiles;
        step_a_d = tile_step_a;
        step_b_d = tile_step_b;
        addr_a_d = base_addr_a;
        addr_b_d = base_addr_b;
        addr_c_d = base_addr_c;
        tile_d   = '0;
        acc_d    = 1'b0;
        if (num_k_tiles == '0) begin
          // Zero-pass job completes immediately and never touches the core.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d      = 1'b1;
          pe_resetn_d = 1'b0;
          state_d     = S_PE_CLR;
        end
      end

      S_PE_CLR: begin
        pe_resetn_d = 1'b1;
        start_d     = 1'b1;
        state_d     = S_WAIT;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end

      S_WAIT: begin
        if (done_mat_mul) begin
          start_d = 1'b0;
          if (tile_q == num_q - TILE_CNT_WIDTH'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            tile_d   = tile_q + TILE_CNT_WIDTH'(1);
            addr_a_d = addr_a_q + AWIDTH'(step_a_q);
            addr_b_d = addr_b_q + AWIDTH'(step_b_q);
            acc_d    = 1'b1;
            state_d  = S_GAP;
          end
`ifdef MATMUL_SEQ_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end

      S_GAP: begin
        start_d = 1'b1;
        state_d = S_WAIT;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_DONE: if (clear_done_reg) begin
        done_d  = 1'b0;
        state_d = S_IDLE;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      pe_resetn_q <= 1'b1;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      acc_q       <= 1'b0;
      tile_q      <= '0;
      num_q       <= '0;
      step_a_q    <= '0;
      step_b_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      start_q     <= start_d;
      pe_resetn_q <= pe_resetn_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      addr_c_q    <= addr_c_d;
      acc_q       <= acc_d;
      tile_q      <= tile_d;
      num_q       <= num_d;
      step_a_q    <= step_a_d;
      step_b_q    <= step_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign start_mat_mul = start_q;
  assign pe_resetn     = pe_resetn_q;
  assign address_mat_a = addr_a_q;
  assign address_mat_b = addr_b_q;
  assign address_mat_c = addr_c_q;
  assign accumulate    = acc_q;
  assign tile_idx      = tile_q;
  assign busy          = busy_q;
  assign done_reg      = done_q;
`ifdef MATMUL_SEQ_TIMEOUT_EN
  assign error_reg     = err_q;
`else
  assign error_reg     = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: table of multi-pass jobs plus hand-written corner sequences.
// Timeout checks follow MATMUL_SEQ_TIMEOUT_EN (macro on: TIMEOUT_CYCLES overridden to 100).
module tb_matmul_tile_sequencer;

  localparam int AW = 11;
  localparam int SW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start_reg = 1'b0;
  logic          clear_done_reg = 1'b0;
  logic [TW-1:0] num_k_tiles = '0;
  logic [AW-1:0] base_addr_a = '0, base_addr_b = '0, base_addr_c = '0;
  logic [SW-1:0] tile_step_a = '0, tile_step_b = '0;
  logic          done_mat_mul = 1'b0;
  logic          start_mat_mul, pe_resetn, accumulate, busy, done_reg, error_reg;
  logic [AW-1:0] address_mat_a, address_mat_b, address_mat_c;
  logic [TW-1:0] tile_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  matmul_tile_sequencer #(
    .AWIDTH(AW), .STRIDE_WIDTH(SW), .TILE_CNT_WIDTH(TW)
`ifdef MATMUL_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .start_reg(start_reg), .clear_done_reg(clear_done_reg),
    .num_k_tiles(num_k_tiles), .base_addr_a(base_addr_a), .base_addr_b(base_addr_b),
    .base_addr_c(base_addr_c), .tile_step_a(tile_step_a), .tile_step_b(tile_step_b),
    .done_mat_mul(done_mat_mul), .start_mat_mul(start_mat_mul), .pe_resetn(pe_resetn),
    .address_mat_a(address_mat_a), .address_mat_b(address_mat_b), .address_mat_c(address_mat_c),
    .accumulate(accumulate), .tile_idx(tile_idx), .busy(busy), .done_reg(done_reg),
    .error_reg(error_reg)
  );

  typedef struct {
    logic [TW-1:0] num;
    logic [AW-1:0] base_a, base_b, base_c;
    logic [SW-1:0] step_a, step_b;
    logic [AW-1:0] exp_a [4];
    logic [AW-1:0] exp_b [4];
  } job_t;

  job_t jobs [4];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " start"}, 32'(start_mat_mul), 32'd0);
    check({tag, " pe_resetn"}, 32'(pe_resetn), 32'd1);
    check({tag, " acc"}, 32'(accumulate), 32'd0);
    check({tag, " tile"}, 32'(tile_idx), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done_reg), 32'd0);
    check({tag, " err"}, 32'(error_reg), 32'd0);
    check({tag, " addr_a"}, 32'(address_mat_a), 32'd0);
    check({tag, " addr_b"}, 32'(address_mat_b), 32'd0);
    check({tag, " addr_c"}, 32'(address_mat_c), 32'd0);
  endtask

  task automatic launch(input job_t j);
    num_k_tiles = j.num;
    base_addr_a = j.base_a;
    base_addr_b = j.base_b;
    base_addr_c = j.base_c;
    tile_step_a = j.step_a;
    tile_step_b = j.step_b;
    start_reg   = 1'b1;
  endtask

  task automatic scramble_config();
    num_k_tiles = 4'hF;
    base_addr_a = 11'h5A5;
    base_addr_b = 11'h2C3;
    base_addr_c = 11'h111;
    tile_step_a = 8'h77;
    tile_step_b = 8'h33;
  endtask

  initial begin
    jobs[0] = '{num: 4'd1, base_a: 11'h010, base_b: 11'h020, base_c: 11'h100, step_a: 8'd0, step_b: 8'd0,
                exp_a: '{11'h010, 11'h0, 11'h0, 11'h0}, exp_b: '{11'h020, 11'h0, 11'h0, 11'h0}};
    jobs[1] = '{num: 4'd3, base_a: 11'h010, base_b: 11'h000, base_c: 11'h300, step_a: 8'd8, step_b: 8'd64,
                exp_a: '{11'h010, 11'h018, 11'h020, 11'h0}, exp_b: '{11'h000, 11'h040, 11'h080, 11'h0}};
    jobs[2] = '{num: 4'd2, base_a: 11'h7F8, base_b: 11'h7C0, base_c: 11'h7FF, step_a: 8'd16, step_b: 8'h80,
                exp_a: '{11'h7F8, 11'h008, 11'h0, 11'h0}, exp_b: '{11'h7C0, 11'h040, 11'h0, 11'h0}};
    jobs[3] = '{num: 4'd4, base_a: 11'h123, base_b: 11'h001, base_c: 11'h000, step_a: 8'hFF, step_b: 8'd1,
                exp_a: '{11'h123, 11'h222, 11'h321, 11'h420}, exp_b: '{11'h001, 11'h002, 11'h003, 11'h004}};

    #12;
    check_reset_values("reset");
    resetn = 1'b1;
    tick();

    // Table-driven multi-pass jobs, config scrambled after capture.
    for (int k = 0; k < 4; k++) begin
      launch(jobs[k]);
      tick();
      start_reg = 1'b0;
      scramble_config();
      check($sformatf("j%0d pe_clr pe_resetn", k), 32'(pe_resetn), 32'd0);
      check($sformatf("j%0d pe_clr busy", k), 32'(busy), 32'd1);
      check($sformatf("j%0d pe_clr start", k), 32'(start_mat_mul), 32'd0);
      tick();
      check($sformatf("j%0d wait pe_resetn", k), 32'(pe_resetn), 32'd1);
      for (int p = 0; p < int'(jobs[k].num); p++) begin
        check($sformatf("j%0d p%0d start", k, p), 32'(start_mat_mul), 32'd1);
        check($sformatf("j%0d p%0d addr_a", k, p), 32'(address_mat_a), 32'(jobs[k].exp_a[p]));
        check($sformatf("j%0d p%0d addr_b", k, p), 32'(address_mat_b), 32'(jobs[k].exp_b[p]));
        check($sformatf("j%0d p%0d addr_c", k, p), 32'(address_mat_c), 32'(jobs[k].base_c));
        check($sformatf("j%0d p%0d tile", k, p), 32'(tile_idx), 32'(p));
        check($sformatf("j%0d p%0d acc", k, p), 32'(accumulate), 32'(p != 0));
        for (int w = 0; w <= p; w++) tick();
        check($sformatf("j%0d p%0d start held", k, p), 32'(start_mat_mul), 32'd1);
        done_mat_mul = 1'b1;
        tick();
        done_mat_mul = 1'b0;
        check($sformatf("j%0d p%0d start drop", k, p), 32'(start_mat_mul), 32'd0);
        if (p == int'(jobs[k].num) - 1) begin
          check($sformatf("j%0d done", k), 32'(done_reg), 32'd1);
          check($sformatf("j%0d busy end", k), 32'(busy), 32'd0);
        end else begin
          check($sformatf("j%0d p%0d busy gap", k, p), 32'(busy), 32'd1);
          check($sformatf("j%0d p%0d done gap", k, p), 32'(done_reg), 32'd0);
          tick();
        end
      end
      tick();
      check($sformatf("j%0d done hold", k), 32'(done_reg), 32'd1);
      check($sformatf("j%0d pe_resetn idle", k), 32'(pe_resetn), 32'd1);
      clear_done_reg = 1'b1;
      tick();
      clear_done_reg = 1'b0;
      check($sformatf("j%0d cleared", k), 32'(done_reg), 32'd0);
    end

    // Zero-tile job: done next cycle, core untouched.
    num_k_tiles = 4'd0;
    start_reg   = 1'b1;
    tick();
    start_reg = 1'b0;
    check("zero done", 32'(done_reg), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("zero start", 32'(start_mat_mul), 32'd0);
      check("zero pe_resetn", 32'(pe_resetn), 32'd1);
      tick();
    end

    // Clear and start together in DONE: clear wins, start taken the next cycle.
    num_k_tiles    = 4'd1;
    start_reg      = 1'b1;
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
    check("clr+start done", 32'(done_reg), 32'd0);
    check("clr+start idle pe_resetn", 32'(pe_resetn), 32'd1);
    tick();
    start_reg = 1'b0;
    check("clr+start pe_clr", 32'(pe_resetn), 32'd0);
    tick();
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    check("clr+start job done", 32'(done_reg), 32'd1);
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;

    // Start pulsed mid-job is ignored; async reset in WAIT of tile 1.
    launch(jobs[1]);
    tick();
    start_reg = 1'b0;
    tick();
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    tick();
    start_reg = 1'b1;
    tick();
    start_reg = 1'b0;
    check("busy start tile", 32'(tile_idx), 32'd1);
    check("busy start pe_resetn", 32'(pe_resetn), 32'd1);
    check("busy start running", 32'(start_mat_mul), 32'd1);
    #3 resetn = 1'b0;
    #1;
    check_reset_values("async rst");
    #2 resetn = 1'b1;
    tick();
    check("post rst idle", 32'(start_mat_mul), 32'd0);

`ifdef MATMUL_SEQ_TIMEOUT_EN
    num_k_tiles = 4'd1;
    start_reg   = 1'b1;
    tick();
    start_reg = 1'b0;
    tick();
    for (int i = 0; i < 99; i++) tick();
    check("to before err", 32'(error_reg), 32'd0);
    check("to before done", 32'(done_reg), 32'd0);
    tick();
    check("to err", 32'(error_reg), 32'd1);
    check("to done", 32'(done_reg), 32'd1);
    check("to start", 32'(start_mat_mul), 32'd0);
    check("to busy", 32'(busy), 32'd0);
    clear_done_reg = 1'b1;
    tick();
    clear_done_reg = 1'b0;
    check("to clr err", 32'(error_reg), 32'd0);
    check("to clr done", 32'(done_reg), 32'd0);
`else
    num_k_tiles = 4'd1;
    start_reg   = 1'b1;
    tick();
    start_reg = 1'b0;
    for (int i = 0; i < 10000; i++) tick();
    check("no-to start", 32'(start_mat_mul), 32'd1);
    check("no-to busy", 32'(busy), 32'd1);
    check("no-to err", 32'(error_reg), 32'd0);
    check("no-to done", 32'(done_reg), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
